// File: rtl/collatz_core.sv
// Sequential Collatz engine: the seed is loaded byte by byte, then the engine
// iterates one step per clock. Results are read back through a byte-wide mux.
module collatz_core #(
   parameter int WIDTH   = 32,
   parameter int STEPS_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       load_byte,
   input  logic [7:0] load_data,
   input  logic       start,
   output logic       busy,
   output logic       done,
   input  logic [2:0] rd_sel,
   output logic [7:0] rd_data
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [WIDTH-1:0]   N_ONE    = WIDTH'(1);
   localparam logic [WIDTH+1:0]   T_ONE    = (WIDTH + 2)'(1);
   localparam logic [STEPS_W-1:0] STEP_ONE = STEPS_W'(1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     seed_q, seed_d;
   logic [WIDTH-1:0]     n_q, n_d;
   logic [WIDTH-1:0]     peak_q, peak_d;
   logic [STEPS_W-1:0]   steps_q, steps_d;
   logic                 ovf_q, ovf_d;
   logic                 zero_err_q, zero_err_d;
   logic                 sat_q, sat_d;

   logic [WIDTH-1:0]     seed_shift;
   logic [WIDTH+1:0]     n_ext;
   logic [WIDTH+1:0]     t_val;

   // A single-byte seed is simply replaced; wider seeds shift in MSB-first.
   if (WIDTH == 8) begin : g_seed_byte
      assign seed_shift = load_data;
   end else begin : g_seed_wide
      assign seed_shift = {seed_q[WIDTH-9:0], load_data};
   end

   // 3n+1 carried in two extra bits so overflow shows up in the top bits.
   assign n_ext = {2'b00, n_q};
   assign t_val = (n_ext << 1) + n_ext + T_ONE;

   always_comb begin
      state_d    = state_q;
      seed_d     = seed_q;
      n_d        = n_q;
      peak_d     = peak_q;
      steps_d    = steps_q;
      ovf_d      = ovf_q;
      zero_err_d = zero_err_q;
      sat_d      = sat_q;
      case (state_q)
         IDLE, DONE: begin
            if (load_byte) begin
               seed_d = seed_shift;
            end else if (start) begin
               n_d        = seed_q;
               peak_d     = seed_q;
               steps_d    = '0;
               ovf_d      = 1'b0;
               zero_err_d = 1'b0;
               sat_d      = 1'b0;
               if (seed_q == '0) begin
                  zero_err_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (n_q == N_ONE) begin
               state_d = DONE;
            end else if (&steps_q) begin
               sat_d   = 1'b1;
               state_d = DONE;
            end else if (!n_q[0]) begin
               n_d     = n_q >> 1;
               steps_d = steps_q + STEP_ONE;
            end else if (t_val[WIDTH+1:WIDTH] != 2'b00) begin
               ovf_d   = 1'b1;
               state_d = DONE;
            end else begin
               n_d     = t_val[WIDTH-1:0];
               steps_d = steps_q + STEP_ONE;
               if (t_val[WIDTH-1:0] > peak_q) peak_d = t_val[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         seed_q     <= '0;
         n_q        <= '0;
         peak_q     <= '0;
         steps_q    <= '0;
         ovf_q      <= 1'b0;
         zero_err_q <= 1'b0;
         sat_q      <= 1'b0;
      end else if (ena) begin
         state_q    <= state_d;
         seed_q     <= seed_d;
         n_q        <= n_d;
         peak_q     <= peak_d;
         steps_q    <= steps_d;
         ovf_q      <= ovf_d;
         zero_err_q <= zero_err_d;
         sat_q      <= sat_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   logic [31:0] peak_ext;
   logic [15:0] steps_ext;

   // Zero-extension makes bytes beyond the configured widths read as 0.
   assign peak_ext  = 32'(peak_q);
   assign steps_ext = 16'(steps_q);

   always_comb begin
      rd_data = 8'h00;
      case (rd_sel)
         3'd0: rd_data = peak_ext[7:0];
         3'd1: rd_data = peak_ext[15:8];
         3'd2: rd_data = peak_ext[23:16];
         3'd3: rd_data = peak_ext[31:24];
         3'd4: rd_data = steps_ext[7:0];
         3'd5: rd_data = steps_ext[15:8];
         3'd6: rd_data = {4'b0000, sat_q, zero_err_q, ovf_q, done};
         3'd7: rd_data = n_q[7:0];
         default: rd_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_collatz_core.sv
// Directed bench for collatz_core: a 16-bit-step instance and an 8-bit-step
// instance share all inputs; expected values are hand-derived Collatz results.
module tb_collatz_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       load_byte;
   logic [7:0] load_data;
   logic       start;
   logic [2:0] rd_sel;
   logic       busy, done;
   logic [7:0] rd_data;
   logic       busy8, done8;
   logic [7:0] rd_data8;

   int checks = 0;
   int errors = 0;

   collatz_core #(.WIDTH(32), .STEPS_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .load_byte(load_byte),
      .load_data(load_data), .start(start), .busy(busy), .done(done),
      .rd_sel(rd_sel), .rd_data(rd_data)
   );

   collatz_core #(.WIDTH(32), .STEPS_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .load_byte(load_byte),
      .load_data(load_data), .start(start), .busy(busy8), .done(done8),
      .rd_sel(rd_sel), .rd_data(rd_data8)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic load_seed(input logic [31:0] v);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         load_byte = 1'b1;
         load_data = v[31-8*i -: 8];
      end
      @(negedge clk);
      load_byte = 1'b0;
   endtask

   // Pulses start and counts posedges (including the sampling edge) until done.
   task automatic run_wait(input bit use8, input int limit, output int cyc,
                           output bit busy_seen);
      @(negedge clk);
      start     = 1'b1;
      cyc       = -1;
      busy_seen = 1'b0;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (use8 ? busy8 : busy) busy_seen = 1'b1;
         if (use8 ? done8 : done) begin
            cyc = i;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic rd(input logic [2:0] s, output logic [7:0] d, output logic [7:0] d8);
      rd_sel = s;
      #1;
      d  = rd_data;
      d8 = rd_data8;
   endtask

   // Tests
   task automatic test_reset;
      logic [7:0] d, d8;
      rst_n = 1'b0; ena = 1'b1; load_byte = 1'b0; load_data = 8'h00;
      start = 1'b0; rd_sel = 3'd0;
      #3;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
      end
      for (int s = 0; s < 8; s++) begin
         rd(3'(s), d, d8);
         checks++;
         if (d !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd%0d: got %02h expected 00", s, d);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_seed6;
      int cyc; bit bs;
      logic [7:0] d, d8;
      logic [7:0] exp_v [8] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h01, 8'h01};
      load_seed(32'd6);
      run_wait(1'b0, 200, cyc, bs);
      checks++;
      if (cyc !== 10) begin
         errors++;
         $display("FAIL seed6_latency: got %0d expected 10", cyc);
      end
      for (int s = 0; s < 8; s++) begin
         rd(3'(s), d, d8);
         checks++;
         if (d !== exp_v[s]) begin
            errors++;
            $display("FAIL seed6_rd%0d: got %02h expected %02h", s, d, exp_v[s]);
         end
      end
   endtask

   task automatic test_seed27;
      int cyc; bit bs;
      logic [7:0] d, d8;
      logic [7:0] exp_v [8] = '{8'h10, 8'h24, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h01, 8'h01};
      load_seed(32'd27);
      run_wait(1'b0, 300, cyc, bs);
      checks++;
      if (cyc !== 113) begin
         errors++;
         $display("FAIL seed27_latency: got %0d expected 113", cyc);
      end
      for (int s = 0; s < 8; s++) begin
         rd(3'(s), d, d8);
         checks++;
         if (d !== exp_v[s]) begin
            errors++;
            $display("FAIL seed27_rd%0d: got %02h expected %02h", s, d, exp_v[s]);
         end
      end
   endtask

   task automatic test_seed1_and_0;
      int cyc; bit bs;
      logic [7:0] d, d8;
      load_seed(32'd1);
      run_wait(1'b0, 20, cyc, bs);
      checks++;
      if (cyc !== 2) begin
         errors++;
         $display("FAIL seed1_latency: got %0d expected 2", cyc);
      end
      rd(3'd4, d, d8);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL seed1_steps: got %02h expected 00", d);
      end
      rd(3'd0, d, d8);
      checks++;
      if (d !== 8'h01) begin
         errors++;
         $display("FAIL seed1_peak: got %02h expected 01", d);
      end
      load_seed(32'd0);
      run_wait(1'b0, 20, cyc, bs);
      checks++;
      if (cyc !== 1 || bs !== 1'b0) begin
         errors++;
         $display("FAIL seed0_done: got cyc=%0d busy_seen=%b expected 1 0", cyc, bs);
      end
      rd(3'd6, d, d8);
      checks++;
      if (d !== 8'h05) begin
         errors++;
         $display("FAIL seed0_status: got %02h expected 05", d);
      end
   endtask

   // Seed is 0 on entry; a load+start in one cycle must load 5 and not start.
   task automatic test_load_start_and_back_to_back;
      int cyc; bit bs;
      logic [7:0] d, d8;
      @(negedge clk);
      load_byte = 1'b1; start = 1'b1; load_data = 8'h05;
      @(posedge clk);
      #1;
      load_byte = 1'b0; start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL load_wins: got busy=%b done=%b expected 0 1", busy, done);
      end
      for (int r = 0; r < 2; r++) begin
         run_wait(1'b0, 50, cyc, bs);
         checks++;
         if (cyc !== 7) begin
            errors++;
            $display("FAIL seed5_run%0d_latency: got %0d expected 7", r, cyc);
         end
         rd(3'd4, d, d8);
         checks++;
         if (d !== 8'h05) begin
            errors++;
            $display("FAIL seed5_run%0d_steps: got %02h expected 05", r, d);
         end
         rd(3'd6, d, d8);
         checks++;
         if (d !== 8'h01) begin
            errors++;
            $display("FAIL seed5_run%0d_status: got %02h expected 01", r, d);
         end
      end
   endtask

   task automatic test_overflow;
      int cyc; bit bs;
      logic [7:0] d, d8;
      logic [7:0] exp_v [4] = '{8'h03, 8'h00, 8'hFF, 8'hFF};
      logic [2:0] sel_v [4] = '{3'd6, 3'd4, 3'd7, 3'd0};
      load_seed(32'hFFFF_FFFF);
      run_wait(1'b0, 20, cyc, bs);
      checks++;
      if (cyc !== 2) begin
         errors++;
         $display("FAIL ovf_latency: got %0d expected 2", cyc);
      end
      for (int k = 0; k < 4; k++) begin
         rd(sel_v[k], d, d8);
         checks++;
         if (d !== exp_v[k]) begin
            errors++;
            $display("FAIL ovf_rd%0d: got %02h expected %02h", sel_v[k], d, exp_v[k]);
         end
      end
   endtask

   task automatic test_ena_midrun;
      int cyc; bit bs;
      logic [7:0] d, d8;
      load_seed(32'd7);
      @(negedge clk);
      start = 1'b1;
      cyc   = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         start     = (i == 3);
         load_byte = (i == 3);
         load_data = 8'h55;
         ena       = !(i >= 6 && i <= 10);
         if (done) begin
            cyc = i;
            break;
         end
      end
      start = 1'b0; load_byte = 1'b0; ena = 1'b1;
      checks++;
      if (cyc !== 23) begin
         errors++;
         $display("FAIL ena_latency: got %0d expected 23", cyc);
      end
      rd(3'd4, d, d8);
      checks++;
      if (d !== 8'h10) begin
         errors++;
         $display("FAIL ena_steps: got %02h expected 10", d);
      end
      rd(3'd0, d, d8);
      checks++;
      if (d !== 8'h34) begin
         errors++;
         $display("FAIL ena_peak: got %02h expected 34", d);
      end
      run_wait(1'b0, 50, cyc, bs);
      checks++;
      if (cyc !== 18) begin
         errors++;
         $display("FAIL seed7_rerun_latency: got %0d expected 18", cyc);
      end
   endtask

   // 77031 needs 350 steps: the 8-bit counter saturates, the 16-bit one does not.
   task automatic test_saturation;
      int cyc, total; bit bs;
      logic [7:0] d, d8;
      load_seed(32'd77031);
      run_wait(1'b1, 400, cyc, bs);
      checks++;
      if (cyc !== 257) begin
         errors++;
         $display("FAIL sat_latency: got %0d expected 257", cyc);
      end
      rd(3'd4, d, d8);
      checks++;
      if (d8 !== 8'hFF) begin
         errors++;
         $display("FAIL sat_steps: got %02h expected ff", d8);
      end
      rd(3'd5, d, d8);
      checks++;
      if (d8 !== 8'h00) begin
         errors++;
         $display("FAIL sat_steps_hi: got %02h expected 00", d8);
      end
      rd(3'd6, d, d8);
      checks++;
      if (d8 !== 8'h09) begin
         errors++;
         $display("FAIL sat_status: got %02h expected 09", d8);
      end
      total = -1;
      for (int i = cyc + 1; i <= 500; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            total = i;
            break;
         end
      end
      checks++;
      if (total !== 352) begin
         errors++;
         $display("FAIL long_latency: got %0d expected 352", total);
      end
      rd(3'd4, d, d8);
      checks++;
      if (d !== 8'h5E) begin
         errors++;
         $display("FAIL long_steps_lo: got %02h expected 5e", d);
      end
      rd(3'd5, d, d8);
      checks++;
      if (d !== 8'h01) begin
         errors++;
         $display("FAIL long_steps_hi: got %02h expected 01", d);
      end
   endtask

   task automatic test_reset_midrun;
      logic [7:0] d, d8;
      load_seed(32'd27);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset_flags: got busy=%b done=%b busy8=%b expected 0 0 0",
                  busy, done, busy8);
      end
      for (int s = 0; s < 8; s++) begin
         rd(3'(s), d, d8);
         checks++;
         if (d !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset_rd%0d: got %02h expected 00", s, d);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_seed6();
      test_seed27();
      test_seed1_and_0();
      test_load_start_and_back_to_back();
      test_overflow();
      test_ena_midrun();
      test_saturation();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
